fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 8 +
 rtl/rr_pick.sv | 26 ++
 rtl/fifo_wr_arb.sv | 101 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int BURST_MAX_DEF = 4;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit after 'last', wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  int pos;

  // Scan farthest-first so the nearest candidate after 'last' wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      pos = (int'(last) + k) % NREQ;
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter for a shared FIFO write port.
// Optional per-requester accepted-word counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         ack,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [DW-1:0]           fifo_w_data,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [NREQ*16-1:0]      stat_cnt
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_e    r_state, w_state_nx;
  logic [IW-1:0] r_owner, w_owner_nx;
  logic [IW-1:0] r_last, w_last_nx;
  logic [BW-1:0] r_beat, w_beat_nx;
  logic          w_pick_vld;
  logic [IW-1:0] w_pick_idx;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (r_last),
    .valid (w_pick_vld),
    .idx   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IW'(NREQ - 1);
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_last  <= w_last_nx;
      r_beat  <= w_beat_nx;
    end
  end

  assign fifo_wr     = (r_state == BURST) & req[r_owner] & ~fifo_full;
  assign fifo_w_data = req_data[r_owner*DW +: DW];
  assign owner       = r_owner;
  assign busy        = (r_state == BURST);

  always_comb begin
    ack          = '0;
    ack[r_owner] = fifo_wr;
  end

  // A dropped req releases the grant even while the FIFO is full.
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_last_nx  = r_last;
    w_beat_nx  = r_beat;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nx = BURST;
          w_owner_nx = w_pick_idx;
          w_beat_nx  = '0;
        end
      end
      BURST: begin
        if (!req[r_owner] || (fifo_wr && r_beat == BW'(BURST_MAX - 1))) begin
          w_state_nx = IDLE;
          w_last_nx  = r_owner;
        end else if (fifo_wr) begin
          w_beat_nx = r_beat + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        r_cnt <= '0;
      else if (ack[g] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
    assign stat_cnt[g*16 +: 16] = r_cnt;
  end
`else
  assign stat_cnt = '0;
`endif
endmodule
